ram_ctrl: RTL and testbench

//  Command-side controller sitting directly upstream of the lab's 16x4 synchronous RAM.

---
 rtl/ram_ctrl_pkg.sv | 18 +
 rtl/ram_ctrl.sv | 152 +++++++++++++++
 tb/tb_ram_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_ctrl_pkg: state encodings and command constants for ram_ctrl.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ram_ctrl_pkg;

  localparam logic [2:0] S_CLEAR   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_CAP  = 3'd4;

  localparam logic CMD_WR = 1'b1;
  localparam logic CMD_RD = 1'b0;

endpackage
`default_nettype wire

// File: rtl/ram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ram_ctrl: command-side controller for an external synchronous RAM.   |
// | Optional RAM_CLEAR_EN: zero-fill sweep of the RAM after reset.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              clear_done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_q
);

`ifdef RAM_CLEAR_EN
  localparam logic [2:0] c_rst_state = S_CLEAR;
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);
`else
  localparam logic [2:0] c_rst_state = S_IDLE;
`endif

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              w_accept;
  logic              w_addr_ok;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;
  logic              w_rd_valid_nxt;
  logic [DATA_W-1:0] w_rd_data_nxt;
  logic              w_err_nxt;

  assign cmd_ready = (r_state == S_IDLE);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_addr_ok = (32'(cmd_addr) < 32'(DEPTH));

`ifdef RAM_CLEAR_EN
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_clear_done;
  logic              w_clr_last;

  // The last sweep write is the cycle ram_we is high on the top address.
  assign w_clr_last = ram_we && (ram_addr == c_last_addr);
  assign clear_done = r_clear_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_addr   <= '0;
      r_clear_done <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      if (w_clr_last) r_clear_done <= 1'b1;
      else            r_clr_addr   <= r_clr_addr + 1'b1;
    end
  end
`else
  assign clear_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_rst_state;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef RAM_CLEAR_EN
      S_CLEAR:   if (w_clr_last) w_state_nxt = S_IDLE;
`endif
      S_IDLE:
        if (w_accept && w_addr_ok)
          w_state_nxt = (cmd_wr == CMD_WR) ? S_WRITE : S_RD_ADDR;
      S_WRITE:   w_state_nxt = S_IDLE;
      S_RD_ADDR: w_state_nxt = S_RD_CAP;
      S_RD_CAP:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = c_rst_state;
    endcase
  end

  // Next values of the registered outputs; address and data hold by default.
  always_comb begin
    w_we_nxt       = 1'b0;
    w_addr_nxt     = ram_addr;
    w_wdata_nxt    = ram_wdata;
    w_rd_valid_nxt = 1'b0;
    w_rd_data_nxt  = rd_data;
    w_err_nxt      = 1'b0;
    case (r_state)
`ifdef RAM_CLEAR_EN
      S_CLEAR:
        if (!w_clr_last) begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_clr_addr;
          w_wdata_nxt = '0;
        end
`endif
      S_IDLE:
        if (w_accept) begin
          if (!w_addr_ok) begin
            w_err_nxt = 1'b1;
          end else if (cmd_wr == CMD_WR) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = cmd_addr;
            w_wdata_nxt = cmd_wdata;
          end else begin
            w_addr_nxt = cmd_addr;
          end
        end
      S_RD_CAP: begin
        w_rd_valid_nxt = 1'b1;
        w_rd_data_nxt  = ram_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      err       <= 1'b0;
    end else begin
      ram_we    <= w_we_nxt;
      ram_addr  <= w_addr_nxt;
      ram_wdata <= w_wdata_nxt;
      rd_valid  <= w_rd_valid_nxt;
      rd_data   <= w_rd_data_nxt;
      err       <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ram_ctrl: ram_ctrl paired with a 16x4 RAM model (DEPTH=16), plus  |
// | a second DEPTH=12 instance for out-of-range commands. RAM_CLEAR_EN.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ram_ctrl;
  import ram_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [3:0] cmd_addr = '0, cmd_wdata = '0;
  logic       cmd_ready, rd_valid, err, clear_done, ram_we;
  logic [3:0] rd_data, ram_addr, ram_wdata, ram_q;

  logic       b_cmd_valid = 1'b0, b_cmd_wr = 1'b0;
  logic [3:0] b_cmd_addr = '0, b_cmd_wdata = '0;
  logic       b_cmd_ready, b_rd_valid, b_err, b_clear_done, b_ram_we;
  logic [3:0] b_rd_data, b_ram_addr, b_ram_wdata;
  logic [3:0] b_ram_q = 4'h0;

  ram_ctrl #(.DATA_W(4), .ADDR_W(4), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .err(err), .clear_done(clear_done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  ram_ctrl #(.DATA_W(4), .ADDR_W(4), .DEPTH(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_wr(b_cmd_wr), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .err(b_err), .clear_done(b_clear_done),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_q(b_ram_q)
  );

  // 16x4 RAM with registered read address; nonzero power-up so a clear is visible.
  logic [3:0] mem [16] = '{default: 4'hF};
  logic [3:0] addr_q = 4'h0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    addr_q <= ram_addr;
  end
  assign ram_q = mem[addr_q];

  int checks = 0, failures = 0;
  int cyc = 0, last_acc = 0, prev_acc = 0, rv_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      prev_acc <= last_acc;
      last_acc <= cyc;
    end
    if (rd_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 1);
  endtask

  task automatic wait_clear();
    int n = 0;
    while (!(clear_done && b_clear_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("clear_done_both", 32'(clear_done && b_clear_done), 1);
  endtask

  // Issue one command and check the cycle-exact response on the main instance.
  task automatic run_cmd(input logic wr, input logic [3:0] addr, input logic [3:0] wd,
                         input logic [3:0] exp_q);
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (wr == CMD_WR) begin
      check("wr_we_t1", 32'(ram_we), 1);
      check("wr_addr_t1", 32'(ram_addr), 32'(addr));
      check("wr_data_t1", 32'(ram_wdata), 32'(wd));
      check("wr_busy_t1", 32'(cmd_ready), 0);
      @(negedge clk);
      check("wr_we_t2", 32'(ram_we), 0);
      check("wr_ready_t2", 32'(cmd_ready), 1);
    end else begin
      check("rd_we_t1", 32'(ram_we), 0);
      check("rd_addr_t1", 32'(ram_addr), 32'(addr));
      @(negedge clk);
      check("rd_valid_t2", 32'(rd_valid), 0);
      @(negedge clk);
      check("rd_valid_t3", 32'(rd_valid), 1);
      check("rd_data_t3", 32'(rd_data), 32'(exp_q));
      check("rd_ready_t3", 32'(cmd_ready), 1);
      @(negedge clk);
      check("rd_valid_t4", 32'(rd_valid), 0);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [3:0] wdata;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k, n, rv0;
    vecs[0] = '{CMD_WR, 4'd3,  4'hA, 4'h0};
    vecs[1] = '{CMD_RD, 4'd3,  4'h0, 4'hA};
    vecs[2] = '{CMD_WR, 4'd15, 4'h6, 4'h0};
    vecs[3] = '{CMD_RD, 4'd15, 4'h0, 4'h6};
    vecs[4] = '{CMD_WR, 4'd3,  4'h9, 4'h0};
    vecs[5] = '{CMD_RD, 4'd3,  4'h0, 4'h9};

    repeat (3) @(negedge clk);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
`ifdef RAM_CLEAR_EN
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_clear_done", 32'(clear_done), 0);
`else
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_clear_done", 32'(clear_done), 1);
`endif
    rst_n = 1'b1;

`ifdef RAM_CLEAR_EN
    k = 0; n = 0;
    while (!clear_done && n < 60) begin
      @(negedge clk);
      n++;
      if (ram_we) begin
        check("clr_addr", 32'(ram_addr), 32'(k));
        check("clr_wdata", 32'(ram_wdata), 0);
        check("clr_ready_low", 32'(cmd_ready), 0);
        k++;
      end
    end
    check("clr_count", 32'(k), 16);
    check("clr_done", 32'(clear_done), 1);
    check("clr_ready", 32'(cmd_ready), 1);
    wait_clear();
    run_cmd(CMD_RD, 4'd9, 4'h0, 4'h0);
`else
    @(negedge clk);
`endif

    for (int i = 0; i < 6; i++) run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_q);

    // Back-to-back: cmd_valid held through the busy cycle.
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_wr = CMD_WR; cmd_addr = 4'd0; cmd_wdata = 4'h5;
    @(negedge clk);
    check("b2b_we", 32'(ram_we), 1);
    cmd_wr = CMD_RD;
    @(negedge clk);
    check("b2b_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_gap", 32'(last_acc - prev_acc), 2);
    @(negedge clk);
    @(negedge clk);
    check("b2b_rd_valid", 32'(rd_valid), 1);
    check("b2b_rd_data", 32'(rd_data), 32'h5);

    // Out-of-range commands on the DEPTH=12 instance.
    @(negedge clk);
    b_cmd_valid = 1'b1; b_cmd_wr = CMD_RD; b_cmd_addr = 4'd13;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    check("ill13_err", 32'(b_err), 1);
    check("ill13_we", 32'(b_ram_we), 0);
    check("ill13_ready", 32'(b_cmd_ready), 1);
    @(negedge clk);
    check("ill13_err_t2", 32'(b_err), 0);
    @(negedge clk);
    check("ill13_rd_valid", 32'(b_rd_valid), 0);
    b_cmd_valid = 1'b1; b_cmd_wr = CMD_WR; b_cmd_addr = 4'd12; b_cmd_wdata = 4'h7;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    check("ill12_err", 32'(b_err), 1);
    check("ill12_we", 32'(b_ram_we), 0);
    b_cmd_valid = 1'b1; b_cmd_wr = CMD_RD; b_cmd_addr = 4'd11;
    @(negedge clk);
    b_cmd_valid = 1'b0;
    check("leg11_err", 32'(b_err), 0);
    check("leg11_addr", 32'(b_ram_addr), 11);
    check("leg11_busy", 32'(b_cmd_ready), 0);
    @(negedge clk);
    @(negedge clk);
    check("leg11_rd_valid", 32'(b_rd_valid), 1);

    // Reset while the read address is being presented to the RAM.
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_wr = CMD_RD; cmd_addr = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_addr", 32'(ram_addr), 3);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rd_data", 32'(rd_data), 0);
    check("mid_ram_addr", 32'(ram_addr), 0);
    check("mid_ram_wdata", 32'(ram_wdata), 0);
    check("mid_ram_we", 32'(ram_we), 0);
    check("mid_rd_valid", 32'(rd_valid), 0);
    check("mid_err", 32'(err), 0);
    rv0 = rv_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_no_rd_valid", 32'(rv_cnt - rv0), 0);
`ifdef RAM_CLEAR_EN
    wait_clear();
`endif

    for (int i = 0; i < 16; i++) run_cmd(CMD_WR, 4'(i), 4'(i), 4'h0);
    for (int i = 0; i < 16; i++) run_cmd(CMD_RD, 4'(i), 4'h0, 4'(i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
